// File: rtl/int_to_fp_arbiter_pkg.sv
// Shared widths and defaults for the int_to_fp requester arbiter.
package int_to_fp_arbiter_pkg;

    localparam int I2F_NUM_REQ    = 4;
    localparam int I2F_ID_W       = 2;
    localparam int I2F_FIFO_DEPTH = 4;
    localparam int I2F_CTRL_W     = 16;

    localparam int I2F_OP_W    = 3;
    localparam int I2F_DATA_W  = 64;
    localparam int I2F_RM_W    = 3;
    localparam int I2F_FLAGS_W = 5;

    // Round-robin successor of a requester index; works for any NUM_REQ.
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1) % n;
    endfunction

endpackage

// File: rtl/int_to_fp_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for ops currently inside the int_to_fp pipe.
// Push is refused when full and pop is refused when empty, so callers can
// drive raw handshake terms.
module int_to_fp_arbiter_id_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push_en, pop_en;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Next pointers and occupancy; simultaneous push/pop leaves count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ID storage; cleared on reset so the head never reads X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/int_to_fp_arbiter.sv
// Shares one int_to_fp pipeline among NUM_REQ requesters. Round-robin grant
// is combinational; the issuing requester ID is queued so that in-order
// results are steered back to whoever issued them.
module int_to_fp_arbiter
    import int_to_fp_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = I2F_NUM_REQ,
    parameter int ID_W       = I2F_ID_W,
    parameter int FIFO_DEPTH = I2F_FIFO_DEPTH,
    parameter int CTRL_W     = I2F_CTRL_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [I2F_OP_W*NUM_REQ-1:0]   req_op_i,
    input  logic [I2F_DATA_W*NUM_REQ-1:0] req_a_i,
    input  logic [I2F_RM_W*NUM_REQ-1:0]   req_rm_i,
    input  logic [CTRL_W*NUM_REQ-1:0]     req_ctrl_i,
    output logic                          cvt_valid_o,
    input  logic                          cvt_ready_i,
    output logic [I2F_OP_W-1:0]           cvt_op_o,
    output logic [I2F_DATA_W-1:0]         cvt_a_o,
    output logic [I2F_RM_W-1:0]           cvt_rm_o,
    output logic [CTRL_W-1:0]             cvt_ctrl_o,
    input  logic                          cvt_valid_i,
    output logic                          cvt_ready_o,
    input  logic [I2F_DATA_W-1:0]         cvt_result_i,
    input  logic [I2F_FLAGS_W-1:0]        cvt_fflags_i,
    input  logic [CTRL_W-1:0]             cvt_ctrl_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    input  logic [NUM_REQ-1:0]            rsp_ready_i,
    output logic [I2F_DATA_W-1:0]         rsp_result_o,
    output logic [I2F_FLAGS_W-1:0]        rsp_fflags_o,
    output logic [CTRL_W-1:0]             rsp_ctrl_o,
    output logic                          busy_o
);

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant;
    logic [ID_W-1:0]    scan_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [NUM_REQ-1:0] head_oh;
    logic [ID_W-1:0]    head_id;
    logic               any_valid, can_issue, issue, retire;
    logic               fifo_full, fifo_empty;

    // Scan from rr_ptr_q downward in reverse so the nearest valid requester wins.
    always_comb begin
        grant    = '0;
        scan_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (req_valid_i[scan_idx]) grant = scan_idx;
        end
    end

    assign any_valid = |req_valid_i;
    // Full blocks issue even on a same-cycle pop, keeping ready off the pop path.
    assign can_issue = ~fifo_full;
    assign grant_oh  = any_valid ? (NUM_REQ'(1) << grant) : '0;

    assign cvt_valid_o = any_valid & can_issue;
    assign req_ready_o = grant_oh & {NUM_REQ{cvt_ready_i & can_issue}};
    assign cvt_op_o    = req_op_i[int'(grant)*I2F_OP_W +: I2F_OP_W];
    assign cvt_a_o     = req_a_i[int'(grant)*I2F_DATA_W +: I2F_DATA_W];
    assign cvt_rm_o    = req_rm_i[int'(grant)*I2F_RM_W +: I2F_RM_W];
    assign cvt_ctrl_o  = req_ctrl_i[int'(grant)*CTRL_W +: CTRL_W];

    assign issue    = cvt_valid_o & cvt_ready_i;
    assign rr_ptr_d = issue ? ID_W'(rr_next(int'(grant), NUM_REQ)) : rr_ptr_q;

    // Round-robin pointer advances past the requester just issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    // Head-of-line ordering: a stalled head requester blocks everyone behind it.
    assign head_oh      = NUM_REQ'(1) << head_id;
    assign rsp_valid_o  = head_oh & {NUM_REQ{cvt_valid_i & ~fifo_empty}};
    assign cvt_ready_o  = rsp_ready_i[head_id] & ~fifo_empty;
    assign retire       = cvt_valid_i & cvt_ready_o;
    assign rsp_result_o = cvt_result_i;
    assign rsp_fflags_o = cvt_fflags_i;
    assign rsp_ctrl_o   = cvt_ctrl_i;
    assign busy_o       = ~fifo_empty;

    int_to_fp_arbiter_id_fifo #(
        .W     (ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_id_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (issue),
        .push_data_i (grant),
        .pop_i       (retire),
        .head_o      (head_id),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule
